// File: rtl/red_pitaya_na_sweep_ctrl_if.sv
// Bus master link between the network-analyser sweep controller and the IQ block.
// The controller uses the master modport; the IQ block (or a bench model) uses the slave modport.
interface red_pitaya_na_sweep_ctrl_if;
   logic [15:0] m_addr_o;
   logic        m_wen_o;
   logic        m_ren_o;
   logic [31:0] m_wdata_o;
   logic        m_ack_i;
   logic [31:0] m_rdata_i;

   modport master (
      output m_addr_o, m_wen_o, m_ren_o, m_wdata_o,
      input  m_ack_i, m_rdata_i
   );

   modport slave (
      input  m_addr_o, m_wen_o, m_ren_o, m_wdata_o,
      output m_ack_i, m_rdata_i
   );
endinterface

// File: rtl/red_pitaya_na_sweep_ctrl.sv
// Frequency sweep sequencer: per point, program the IQ frequency, poll until ready, read I/Q, emit a result.
// Optional ack timeout with sticky err_o is enabled by defining NA_SWEEP_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start_i
// WR_FREQ | frequency write to 0x108 outstanding
// POLL    | status read of 0x140 outstanding, bit31 set means not ready yet
// RD_IH   | read of 0x144 outstanding (I[61:31])
// RD_QL   | read of 0x148 outstanding (Q[30:0])
// RD_QH   | read of 0x14C outstanding (Q[61:31])
// EMIT    | result presented, waiting for res_ready_i
// NEXT    | advance to the next point or finish
module red_pitaya_na_sweep_ctrl #(
   parameter int PHASEBITS = 32,
   parameter int POINTBITS = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [PHASEBITS-1:0]   f_start_i,
   input  logic [PHASEBITS-1:0]   f_step_i,
   input  logic [POINTBITS-1:0]   n_points_i,
   red_pitaya_na_sweep_ctrl_if.master bus,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [POINTBITS-1:0]   res_idx_o,
   output logic [61:0]            res_i_o,
   output logic [61:0]            res_q_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
);

   localparam logic [15:0] ADDR_FREQ = 16'h0108;
   localparam logic [15:0] ADDR_STAT = 16'h0140;
   localparam logic [15:0] ADDR_IH   = 16'h0144;
   localparam logic [15:0] ADDR_QL   = 16'h0148;
   localparam logic [15:0] ADDR_QH   = 16'h014C;

   typedef enum logic [2:0] {
      IDLE, WR_FREQ, POLL, RD_IH, RD_QL, RD_QH, EMIT, NEXT
   } state_t;

   state_t               state;
   logic [PHASEBITS-1:0] freq_q;
   logic [PHASEBITS-1:0] step_q;
   logic [POINTBITS-1:0] n_pts_q;
   logic [POINTBITS-1:0] idx_q;
   logic [61:0]          i_q;
   logic [30:0]          q_lo_q;

   // A zero wait limit would make the reload value underflow.
   if (TIMEOUT < 1) begin : g_timeout_range
      $error("TIMEOUT must be at least 1");
   end

`ifdef NA_SWEEP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_q;
   logic          access_state;
   logic          tmo_hit;

   assign access_state = (state == WR_FREQ) || (state == POLL) || (state == RD_IH) ||
                         (state == RD_QL)   || (state == RD_QH);
   assign tmo_hit      = access_state && !bus.m_ack_i && (tmo_q == '0);

   // Every strobe leaves from IDLE, NEXT or an ack edge, so reloading there arms the wait window.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tmo_q <= '0;
      end else if (!access_state || bus.m_ack_i) begin
         tmo_q <= TMO_LOAD;
      end else if (tmo_q != '0) begin
         tmo_q <= tmo_q - 1'b1;
      end
   end
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state          <= IDLE;
         freq_q         <= '0;
         step_q         <= '0;
         n_pts_q        <= '0;
         idx_q          <= '0;
         i_q            <= '0;
         q_lo_q         <= '0;
         bus.m_addr_o   <= '0;
         bus.m_wdata_o  <= '0;
         bus.m_wen_o    <= 1'b0;
         bus.m_ren_o    <= 1'b0;
         res_valid_o    <= 1'b0;
         res_idx_o      <= '0;
         res_i_o        <= '0;
         res_q_o        <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
`ifdef NA_SWEEP_TIMEOUT_EN
         err_o          <= 1'b0;
`endif
      end else begin
         done_o      <= 1'b0;
         bus.m_wen_o <= 1'b0;
         bus.m_ren_o <= 1'b0;
         if (abort_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     freq_q  <= f_start_i;
                     step_q  <= f_step_i;
                     n_pts_q <= n_points_i;
                     idx_q   <= '0;
`ifdef NA_SWEEP_TIMEOUT_EN
                     err_o   <= 1'b0;
`endif
                     if (n_points_i == '0) begin
                        done_o <= 1'b1;
                     end else begin
                        busy_o        <= 1'b1;
                        state         <= WR_FREQ;
                        bus.m_wen_o   <= 1'b1;
                        bus.m_addr_o  <= ADDR_FREQ;
                        bus.m_wdata_o <= 32'(f_start_i);
                     end
                  end
               end
               WR_FREQ: begin
                  if (bus.m_ack_i) begin
                     state         <= POLL;
                     bus.m_ren_o   <= 1'b1;
                     bus.m_addr_o  <= ADDR_STAT;
                     bus.m_wdata_o <= '0;
                  end
               end
               POLL: begin
                  if (bus.m_ack_i) begin
                     bus.m_ren_o <= 1'b1;
                     if (!bus.m_rdata_i[31]) begin
                        i_q[30:0]    <= bus.m_rdata_i[30:0];
                        state        <= RD_IH;
                        bus.m_addr_o <= ADDR_IH;
                     end
                  end
               end
               RD_IH: begin
                  if (bus.m_ack_i) begin
                     i_q[61:31]   <= bus.m_rdata_i[30:0];
                     state        <= RD_QL;
                     bus.m_ren_o  <= 1'b1;
                     bus.m_addr_o <= ADDR_QL;
                  end
               end
               RD_QL: begin
                  if (bus.m_ack_i) begin
                     q_lo_q       <= bus.m_rdata_i[30:0];
                     state        <= RD_QH;
                     bus.m_ren_o  <= 1'b1;
                     bus.m_addr_o <= ADDR_QH;
                  end
               end
               RD_QH: begin
                  if (bus.m_ack_i) begin
                     state       <= EMIT;
                     res_valid_o <= 1'b1;
                     res_idx_o   <= idx_q;
                     res_i_o     <= i_q;
                     res_q_o     <= {bus.m_rdata_i[30:0], q_lo_q};
                  end
               end
               EMIT: begin
                  if (res_ready_i) begin
                     res_valid_o <= 1'b0;
                     state       <= NEXT;
                  end
               end
               NEXT: begin
                  if (idx_q == n_pts_q - 1'b1) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     freq_q        <= freq_q + step_q;
                     idx_q         <= idx_q + 1'b1;
                     state         <= WR_FREQ;
                     bus.m_wen_o   <= 1'b1;
                     bus.m_addr_o  <= ADDR_FREQ;
                     bus.m_wdata_o <= 32'(freq_q + step_q);
                  end
               end
               default: state <= IDLE;
            endcase
`ifdef NA_SWEEP_TIMEOUT_EN
            if (tmo_hit) begin
               err_o  <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
`endif
         end
      end
   end

endmodule
